// File: rtl/xcvr_pkg.sv
// Shared transceiver control definitions: state encodings, default widths and
// the per-state output table used by the T/R sequencer.
package xcvr_pkg;

  localparam int CNT_W_DEF = 16;
  localparam int TMO_W_DEF = 32;

  typedef enum logic [2:0] {
    ST_RX     = 3'd0,
    ST_RXMUTE = 3'd1,
    ST_TX     = 3'd2,
    ST_HANG   = 3'd3,
    ST_TXMUTE = 3'd4,
    ST_LOOP   = 3'd5
  } tr_state_e;

  typedef struct packed {
    logic rx_enable;
    logic tx_enable;
    logic ptt;
    logic loopback;
  } tr_out_t;

  function automatic tr_out_t state_outputs(input tr_state_e s);
    tr_out_t o;
    o = '{rx_enable: 1'b1, tx_enable: 1'b0, ptt: 1'b0, loopback: 1'b0};
    case (s)
      ST_RXMUTE: o = '{rx_enable: 1'b0, tx_enable: 1'b0, ptt: 1'b1, loopback: 1'b0};
      ST_TX,
      ST_HANG:   o = '{rx_enable: 1'b0, tx_enable: 1'b1, ptt: 1'b1, loopback: 1'b0};
      ST_TXMUTE: o = '{rx_enable: 1'b0, tx_enable: 1'b0, ptt: 1'b1, loopback: 1'b0};
      ST_LOOP:   o = '{rx_enable: 1'b1, tx_enable: 1'b1, ptt: 1'b0, loopback: 1'b1};
      default:   o = '{rx_enable: 1'b1, tx_enable: 1'b0, ptt: 1'b0, loopback: 1'b0};
    endcase
    return o;
  endfunction

endpackage

// File: rtl/tr_timer.sv
// Loadable down-counter shared by the timed sequencer states. A load of 0 is
// treated as 1 so every timed state lasts at least one cycle.
module tr_timer
  import xcvr_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             expired
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= (load_val == '0) ? CNT_W'(1) : load_val;
    end else if (count != '0) begin
      count <= count - CNT_W'(1);
    end
  end

  // Terminal count: the current cycle is the last one of the timed state.
  assign expired = (count == CNT_W'(1));

endmodule

// File: rtl/tr_sequencer.sv
// Transmit/receive sequencer: orders rx mute, relay (ptt) and tx enable so the
// antenna relay never switches with RF present, plus a transmit timeout.
//
// state     | meaning
// ----------+--------------------------------------------------------
// RX        | receiving, relay at rest
// RXMUTE    | receiver muted, relay switched, waiting before tx on
// TX        | transmitting while key held
// HANG      | key released, tx held for the hang time
// TXMUTE    | tx off, relay still switched, waiting before rx on
// LOOP      | internal loopback test, relay at rest
module tr_sequencer
  import xcvr_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int TMO_W = TMO_W_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             key,
  input  logic             loopback_req,
  input  logic [CNT_W-1:0] cfg_rx_to_tx,
  input  logic [CNT_W-1:0] cfg_tx_hang,
  input  logic [CNT_W-1:0] cfg_tx_to_rx,
  input  logic [TMO_W-1:0] cfg_timeout,
  output logic             rx_enable,
  output logic             tx_enable,
  output logic             loopback,
  output logic             ptt,
  output logic [2:0]       state,
  output logic             timeout_flag
);

  tr_state_e        state_q, state_d;
  tr_out_t          out_d;
  logic             tmr_load, tmr_expired;
  logic [CNT_W-1:0] tmr_val;
  logic [TMO_W-1:0] tmo_cnt, tmo_inc;
  logic             in_tx, tmo_hit, tmo_clr, flag_set, flag_clr;

  tr_timer #(.CNT_W(CNT_W)) u_timer (
    .clock    (clock),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expired  (tmr_expired)
  );

  // Saturating increment keeps a disabled timeout from wrapping.
  assign in_tx   = (state_q == ST_TX) || (state_q == ST_HANG);
  assign tmo_inc = (tmo_cnt == '1) ? tmo_cnt : tmo_cnt + TMO_W'(1);
  assign tmo_hit = in_tx && (cfg_timeout != '0) && (tmo_inc >= cfg_timeout);

  always_comb begin
    state_d  = state_q;
    flag_set = 1'b0;
    flag_clr = 1'b0;
    case (state_q)
      ST_RX: begin
        flag_clr = !key;
        if (key && !timeout_flag) state_d = ST_RXMUTE;
        else if (loopback_req)    state_d = ST_LOOP;
      end
      ST_RXMUTE: begin
        if (!key)             state_d = ST_TXMUTE;
        else if (tmr_expired) state_d = ST_TX;
      end
      ST_TX: begin
        if (tmo_hit) begin
          state_d  = ST_TXMUTE;
          flag_set = 1'b1;
        end else if (!key) begin
          state_d = ST_HANG;
        end
      end
      ST_HANG: begin
        if (tmo_hit) begin
          state_d  = ST_TXMUTE;
          flag_set = 1'b1;
        end else if (key) begin
          state_d = ST_TX;
        end else if (tmr_expired) begin
          state_d = ST_TXMUTE;
        end
      end
      ST_TXMUTE: begin
        if (tmr_expired) state_d = ST_RX;
      end
      ST_LOOP: begin
        if (!loopback_req) state_d = ST_RX;
      end
      default: state_d = ST_RX;
    endcase
  end

  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    if (state_d != state_q) begin
      case (state_d)
        ST_RXMUTE: begin tmr_load = 1'b1; tmr_val = cfg_rx_to_tx; end
        ST_HANG:   begin tmr_load = 1'b1; tmr_val = cfg_tx_hang;  end
        ST_TXMUTE: begin tmr_load = 1'b1; tmr_val = cfg_tx_to_rx; end
        default:   begin tmr_load = 1'b0; tmr_val = '0;           end
      endcase
    end
  end

  assign tmo_clr = (state_q == ST_RXMUTE) && (state_d == ST_TX);
  assign out_d   = state_outputs(state_d);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_RX;
      rx_enable    <= 1'b1;
      tx_enable    <= 1'b0;
      ptt          <= 1'b0;
      loopback     <= 1'b0;
      timeout_flag <= 1'b0;
      tmo_cnt      <= '0;
    end else begin
      state_q   <= state_d;
      rx_enable <= out_d.rx_enable;
      tx_enable <= out_d.tx_enable;
      ptt       <= out_d.ptt;
      loopback  <= out_d.loopback;
      if (flag_set)      timeout_flag <= 1'b1;
      else if (flag_clr) timeout_flag <= 1'b0;
      if (tmo_clr)       tmo_cnt <= '0;
      else if (in_tx)    tmo_cnt <= tmo_inc;
    end
  end

  assign state = state_q;

endmodule

// File: doc/tr_sequencer.md
TR_SEQUENCER -- requirements
Module: tr_sequencer

Interface
REQ-001 Parameter: CNT_W, 16, width of delay/hang configuration inputs.
REQ-002 Parameter: TMO_W, 32, width of transmit-timeout configuration input.
REQ-003 Port: clock  in  1  single clock for all logic (transceiver sample clock domain).
REQ-004 Port: reset  in  1  synchronous, active-high.
REQ-005 Port: key  in  1  transmit request, level-sensitive.
REQ-006 Port: loopback_req  in  1  request internal loopback test mode.
REQ-007 Port: cfg_rx_to_tx  in  CNT_W  cycles the receiver is muted, with PTT asserted, before TX is enabled.
REQ-008 Port: cfg_tx_hang  in  CNT_W  cycles TX is held after key release.
REQ-009 Port: cfg_tx_to_rx  in  CNT_W  cycles TX is off, with PTT still asserted, before RX is re-enabled.
REQ-010 Port: cfg_timeout  in  TMO_W  maximum cycles in TX+HANG; 0 disables the timeout.
REQ-011 Port: rx_enable  out  1  drives the transceiver rx_enable.
REQ-012 Port: tx_enable  out  1  drives the transceiver tx_enable.
REQ-013 Port: loopback  out  1  drives the transceiver loopback.
REQ-014 Port: ptt  out  1  antenna T/R relay drive.
REQ-015 Port: state  out  3  current state encoding, for status readback.
REQ-016 Port: timeout_flag  out  1  sticky indication of a transmit timeout.

Function
REQ-017 The block SHALL implement these states: RX=0, RXMUTE=1, TX=2, HANG=3, TXMUTE=4, LOOP=5; encodings 6 and 7 SHALL return to RX on the next cycle.
REQ-018 All outputs SHALL be registered and SHALL update on the same edge as the state register:
- RX: rx 1, tx 0, ptt 0, lb 0.
- RXMUTE: rx 0, tx 0, ptt 1, lb 0.
- TX and HANG: rx 0, tx 1, ptt 1, lb 0.
- TXMUTE: rx 0, tx 0, ptt 1, lb 0.
- LOOP: rx 1, tx 1, ptt 0, lb 1.
REQ-019 RX transitions:
- key=1 and timeout_flag=0 -> RXMUTE.
- Otherwise, loopback_req=1 -> LOOP; key has priority over loopback_req.
REQ-020 A timed state (RXMUTE, HANG, TXMUTE) SHALL last exactly N cycles, where N is its cfg value sampled on the entry edge; N=0 SHALL be treated as 1.
- Mid-state cfg changes SHALL have no effect on the current state.
REQ-021 RXMUTE transitions:
- On expiry -> TX.
- key=0 before expiry -> TXMUTE, so that the relay settle time is honoured.
REQ-022 TX transitions: key=0 -> HANG.
REQ-023 HANG transitions:
- key=1 -> TX, with the hang count discarded.
- On expiry -> TXMUTE.
REQ-024 TXMUTE transitions: on expiry -> RX; key SHALL be ignored in TXMUTE.
REQ-025 LOOP transitions: loopback_req=0 -> RX; key SHALL be ignored in LOOP.
REQ-026 Timeout counter behaviour:
- Clears on entry to TX from RXMUTE; counts every cycle in TX and HANG; is not cleared by HANG->TX.
- When cfg_timeout!=0 and count reaches cfg_timeout, the FSM SHALL go to TXMUTE and set timeout_flag the same edge.
REQ-027 timeout_flag SHALL clear only in RX when key=0; while set it SHALL block RX->RXMUTE.
REQ-028 tx_enable=1 SHALL never coincide with rx_enable=1 except in LOOP.
REQ-029 ptt SHALL never be 0 while tx_enable=1 outside LOOP.

Reset
REQ-030 While reset=1, on every edge: state RX, rx_enable 1, tx_enable 0, ptt 0, loopback 0, timeout_flag 0, all counters 0.
REQ-031 Reset asserted mid-operation (any state) SHALL force the REQ-030 values on the next edge, with no TXMUTE delay.

Structure
REQ-032 State encodings and CNT_W/TMO_W defaults SHALL live in the shared package xcvr_pkg.
REQ-033 One sub-module, tr_timer, SHALL implement the loadable CNT_W down-counter with load, zero-as-one handling and an expiry pulse; it SHALL be instantiated once and shared by RXMUTE/HANG/TXMUTE.
REQ-034 The timeout counter SHALL be inline in tr_sequencer.

Verification
REQ-035 cfg_rx_to_tx=4, cfg_tx_hang=10, cfg_tx_to_rx=3, key high 20 cycles then low. Required: ptt rises 1 cycle after key, tx_enable rises 4 cycles later, tx_enable falls 10 cycles after HANG entry, rx_enable returns 3 cycles after that.
REQ-036 key released in HANG then reasserted after 5 of 10 cycles. Required: returns to TX, tx_enable never drops, and a fresh full 10-cycle hang follows the next release.
REQ-037 cfg_timeout=50, key held high. Required: TXMUTE after 50 cycles in TX, timeout_flag=1, and no re-key until key=0 seen in RX.
REQ-038 loopback_req=1 with key=0. Required: LOOP, with rx, tx, lb = 1 and ptt=0; key=1 ignored. Then loopback_req=0 gives RX next cycle. Also, key and loopback_req rising together gives RXMUTE.
REQ-039 Boundary cases: all cfg=0 gives 1 cycle per timed state; key drop in RXMUTE goes to TXMUTE with tx_enable never 1; reset in TX gives REQ-030 values next edge.
REQ-040 A bench assertion SHALL check REQ-028 and REQ-029 every cycle under random key, loopback_req, and cfg stimulus.
